// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stages.
// The stall counter width exists only when PIPE_STAGE_STATS_EN is defined.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // Packed payload field widths used by the stage wrappers.
    localparam int RD_W       = 32;
    localparam int WN_W       = 5;
    localparam int ALU_CTL_W  = 3;
    localparam int ID_EX_W    = 3 * RD_W + WN_W + ALU_CTL_W;

`ifdef PIPE_STAGE_STATS_EN
    localparam int STATS_W = 32;
`endif

    // The stage can take a new payload unless both entries are occupied.
    function automatic logic stage_has_room(input stage_state_e s);
        return s != ST_FULL;
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous reset to a fixed value.
module pipe_data_reg #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: main register plus skid entry, registered in_ready.
// Define PIPE_STAGE_STATS_EN to add the saturating stall_cycles counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PIPE_STAGE_STATS_EN
    output logic [STATS_W-1:0] stall_cycles,
`endif
    output logic [DATA_W-1:0] out_data
);

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic              in_ready_q;
    logic              in_ready_d;

    logic              main_en;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;
    logic              skid_en;
    logic [DATA_W-1:0] skid_d;
    logic [DATA_W-1:0] skid_q;

    logic              push;
    logic              pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = BUBBLE_VAL;
        skid_en = 1'b0;
        skid_d  = in_data;

        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_BUSY;
                    main_en = 1'b1;
                    main_d  = in_data;
                end
            end
            ST_BUSY: begin
                if (push && pop) begin
                    main_en = 1'b1;
                    main_d  = in_data;
                end else if (push) begin
                    state_d = ST_FULL;
                    skid_en = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                    main_en = 1'b1;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the skid entry can move up.
                if (pop) begin
                    state_d = ST_BUSY;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_en = 1'b1;
            end
        endcase

        // Squash wins over any handshake; a concurrent push is simply lost.
        if (flush) begin
            state_d = ST_EMPTY;
            main_en = 1'b1;
            main_d  = BUBBLE_VAL;
            skid_en = 1'b0;
        end

        in_ready_d = stage_has_room(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_data_reg #(
        .DATA_W (DATA_W),
        .RST_VAL(BUBBLE_VAL)
    ) u_main (
        .clk(clk),
        .rst(rst),
        .en (main_en),
        .d  (main_d),
        .q  (main_q)
    );

    pipe_data_reg #(
        .DATA_W (DATA_W),
        .RST_VAL({DATA_W{1'b0}})
    ) u_skid (
        .clk(clk),
        .rst(rst),
        .en (skid_en),
        .d  (skid_d),
        .q  (skid_q)
    );

    assign in_ready = in_ready_q;
    assign out_data = main_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [STATS_W-1:0] stall_q;
    logic [STATS_W-1:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {STATS_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: queue model checked every cycle plus literal checks.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cycles(stall_cycles),
`endif
        .out_data (out_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of depth two; out shows the head or zero.
    logic [31:0] mq[$];
    logic [31:0] m_stall = 32'h0;
    bit          model_ok = 1'b0;
    bit          m_push, m_pop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_stall  = 32'h0;
            model_ok = 1'b1;
        end else begin
            m_push = in_valid && (mq.size() < 2);
            m_pop  = (mq.size() > 0) && out_ready;
            if ((mq.size() > 0) && !out_ready && (m_stall != 32'hFFFF_FFFF))
                m_stall = m_stall + 32'd1;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model out_valid", {31'h0, out_valid}, {31'h0, mq.size() > 0});
            check("model in_ready", {31'h0, in_ready}, {31'h0, mq.size() < 2});
            check("model out_data", out_data, (mq.size() > 0) ? mq[0] : 32'h0);
`ifdef PIPE_STAGE_STATS_EN
            check("model stall_cycles", stall_cycles, m_stall);
`endif
        end
    end

    // Advance one clock; inputs set before the call are sampled at that edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
        $display("txn %-22s got %h want %h", name, act, exp);
    endtask

    initial begin
        // 1. reset with a payload pending on the input
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        step();
        lit("rst1 out_valid", {31'h0, out_valid}, 32'h0);
        step();
        lit("rst2 out_data", out_data, 32'h0);
        lit("rst2 in_ready", {31'h0, in_ready}, 32'h1);
        rst = 1'b0;
        step();
        lit("first push data", out_data, 32'hDEAD_BEEF);
        lit("first push valid", {31'h0, out_valid}, 32'h1);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        lit("drain empty", {31'h0, out_valid}, 32'h0);

        // 2. streaming at full throughput
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = i;
            step();
            lit("stream data", out_data, i);
            lit("stream in_ready", {31'h0, in_ready}, 32'h1);
        end
        in_valid = 1'b0;
        step();
        lit("stream end empty", {31'h0, out_valid}, 32'h0);

        // 3. backpressure into the skid entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd5;
        step();
        in_data = 32'd6;
        step();
        lit("full in_ready", {31'h0, in_ready}, 32'h0);
        lit("full head", out_data, 32'd5);
        in_valid = 1'b0;
        step();
        lit("full held", out_data, 32'd5);
        out_ready = 1'b1;
        step();
        lit("skid moved up", out_data, 32'd6);
        lit("ready after pop", {31'h0, in_ready}, 32'h1);
        step();
        lit("skid drained", {31'h0, out_valid}, 32'h0);

        // 4. flush in FULL, then flush in BUSY with a live push
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd10;
        step();
        in_data = 32'd11;
        step();
        flush = 1'b1; in_data = 32'd9;
        step();
        lit("flush full valid", {31'h0, out_valid}, 32'h0);
        lit("flush full data", out_data, 32'h0);
        lit("flush full ready", {31'h0, in_ready}, 32'h1);
        flush = 1'b0; in_data = 32'd12;
        step();
        flush = 1'b1; in_data = 32'd9;
        step();
        lit("flush drops push", {31'h0, out_valid}, 32'h0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        lit("no 9 after flush", out_data, 32'h0);

        // 5. reset while FULL
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd7;
        step();
        in_data = 32'd8;
        step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        lit("rst full valid", {31'h0, out_valid}, 32'h0);
        lit("rst full data", out_data, 32'h0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        step();
        lit("no 7/8 after rst", {31'h0, out_valid}, 32'h0);

        // patterned traffic, keeping in_data stable while stalled
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 3) != 0;
            if (!in_valid || in_ready) begin
                in_valid = (i % 4) != 3;
                in_data  = 32'h100 + i;
            end
            flush = (i == 25);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();

`ifdef PIPE_STAGE_STATS_EN
        // 6. stall counter
        rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        lit("stall count", stall_cycles, 32'd10);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0;
        lit("stall after flush", stall_cycles, 32'd10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        lit("stall after rst", stall_cycles, 32'd0);
        step();
`endif

        @(posedge clk);
        #7;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
